regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file types, special addresses and writeback switch states
package regfile_pkg;

   typedef logic [3:0]  reg_addr_t;
   typedef logic [15:0] reg_data_t;

   localparam reg_addr_t REG_IRA = 4'hC;
   localparam reg_addr_t REG_SP  = 4'hD;
   localparam reg_addr_t REG_SR  = 4'hE;
   localparam reg_addr_t REG_PC  = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      ACK   = 2'd2,
      WAIT  = 2'd3
   } wb_sw_state_t;

   // SP, SR and PC sit at the top of the map and are never written through the writeback port
   function automatic logic reg_writable(input reg_addr_t addr);
      return addr < REG_SP;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rtl/regfile_wb_arbiter_rr_arbiter.sv - combinational round-robin one-hot grant starting at a pointer
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   pointer,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant
);

   logic             found;
   logic [PTR_W-1:0] idx;

   // Scan upward from the pointer (wrapping) and grant the first active request
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((int'(pointer) + k) % NUM_REQ);
         if (enable && !found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback port sharing with bank-switch drain; REGFILE_WB_FWD_EN adds write forwarding
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      hold,
   input  logic                      sw_req,
   output logic                      sw_ack,
   output logic [ADDR_W-1:0]         write_addr,
   output logic [DATA_W-1:0]         write_data,
   output logic                      write_en,
   output logic                      drop_err,
   input  logic                      err_clr
`ifdef REGFILE_WB_FWD_EN
   ,
   input  logic [ADDR_W-1:0]         fwd_addr,
   output logic                      fwd_hit,
   output logic [DATA_W-1:0]         fwd_data
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);

   wb_sw_state_t      state_q;
   logic              sw_ack_q;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              write_en_q, write_en_d;
   logic [ADDR_W-1:0] write_addr_q, write_addr_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic              drop_err_q, drop_err_d;

   logic [NUM_REQ-1:0] grant;
   logic               grant_en;
   logic               transfer;
   logic [PTR_W-1:0]   gidx;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;
   logic               writable;

   // Grants only in IDLE, and not in the cycle a switch request first appears
   assign grant_en = (state_q == IDLE) && !hold && !sw_req;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req     (req_valid),
      .pointer (ptr_q),
      .enable  (grant_en),
      .grant   (grant)
   );

   assign req_ready = grant;
   assign transfer  = |grant;

   // Encode the one-hot grant to select the winning requester's fields
   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) gidx = PTR_W'(i);
      end
   end

   assign sel_addr = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
   assign sel_data = req_data[int'(gidx)*DATA_W +: DATA_W];
   assign writable = reg_writable(reg_addr_t'(sel_addr));

   // Next-state for pointer, output stage and sticky drop flag
   always_comb begin
      ptr_d        = ptr_q;
      write_en_d   = 1'b0;
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
      drop_err_d   = err_clr ? 1'b0 : drop_err_q;
      if (transfer) begin
         ptr_d        = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
         write_en_d   = writable;
         write_addr_d = sel_addr;
         write_data_d = sel_data;
         if (!writable) drop_err_d = 1'b1;
      end
   end

   // Output stage registers; a reset discards any captured write
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q        <= '0;
         write_en_q   <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         drop_err_q   <= 1'b0;
      end else begin
         ptr_q        <= ptr_d;
         write_en_q   <= write_en_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         drop_err_q   <= drop_err_d;
      end
   end

   // Bank-switch handshake: drain the output stage, pulse ack, wait for the request to drop
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sw_ack_q <= 1'b0;
      end else begin
         sw_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sw_req) state_q <= DRAIN;
            end
            DRAIN: begin
               if (!write_en_q) begin
                  state_q  <= ACK;
                  sw_ack_q <= 1'b1;
               end
            end
            ACK: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (!sw_req) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sw_ack     = sw_ack_q;
   assign write_en   = write_en_q;
   assign write_addr = write_addr_q;
   assign write_data = write_data_q;
   assign drop_err   = drop_err_q;

`ifdef REGFILE_WB_FWD_EN
   assign fwd_hit  = write_en_q && (write_addr_q == fwd_addr);
   assign fwd_data = write_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 4;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]  req_ready;
   logic          hold = 1'b0;
   logic          sw_req = 1'b0;
   logic          sw_ack;
   logic [AW-1:0] write_addr;
   logic [DW-1:0] write_data;
   logic          write_en;
   logic          drop_err;
   logic          err_clr = 1'b0;

   always #5 clock = ~clock;

   regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .hold       (hold),
      .sw_req     (sw_req),
      .sw_ack     (sw_ack),
      .write_addr (write_addr),
      .write_data (write_data),
      .write_en   (write_en),
      .drop_err   (drop_err),
      .err_clr    (err_clr)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [2:0]  valid;
      logic [11:0] addr;
      logic [47:0] data;
      logic        clr;
      logic [2:0]  e_ready;
      logic        e_we;
      logic [3:0]  e_wa;
      logic [15:0] e_wd;
      logic        e_drop;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input logic [2:0] v, input logic [11:0] a, input logic [47:0] d,
                               input logic c, input logic [2:0] er, input logic ew,
                               input logic [3:0] ea, input logic [15:0] ed, input logic edr);
      vec_t r;
      r.valid = v; r.addr = a; r.data = d; r.clr = c;
      r.e_ready = er; r.e_we = ew; r.e_wa = ea; r.e_wd = ed; r.e_drop = edr;
      return r;
   endfunction

   // one cycle with expected ready/write_en/sw_ack, then advance to the next negedge
   task automatic cyc(input string nm, input logic [2:0] er, input logic ewe, input logic eack);
      #1;
      chk({nm, "_ready"}, 32'(req_ready), 32'(er));
      chk({nm, "_we"}, 32'(write_en), 32'(ewe));
      chk({nm, "_ack"}, 32'(sw_ack), 32'(eack));
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      req_valid = '0; req_addr = '0; req_data = '0;
      hold = 1'b0; sw_req = 1'b0; err_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      idle_inputs();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   // reference: first valid requester at or above ptr, wrapping
   function automatic int pick(input logic [2:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (ptr + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   int m_ptr, m_phase, gi;
   logic m_we, m_drop;
   logic [3:0] m_wa;
   logic [15:0] m_wd;
   logic [2:0] rv, exp_ready;
   logic [11:0] ra;
   logic [47:0] rd;
   logic rh, rs, rc;
   logic [3:0] ga;

   initial begin
      vecs[0]  = mk(3'b111, 12'h321, 48'hCCCC_BBBB_AAAA, 1'b0, 3'b001, 1'b0, 4'h0, 16'h0000, 1'b0);
      vecs[1]  = mk(3'b111, 12'h321, 48'hCCCC_BBBB_AAAA, 1'b0, 3'b010, 1'b1, 4'h1, 16'hAAAA, 1'b0);
      vecs[2]  = mk(3'b111, 12'h321, 48'hCCCC_BBBB_AAAA, 1'b0, 3'b100, 1'b1, 4'h2, 16'hBBBB, 1'b0);
      vecs[3]  = mk(3'b111, 12'h321, 48'hCCCC_BBBB_AAAA, 1'b0, 3'b001, 1'b1, 4'h3, 16'hCCCC, 1'b0);
      vecs[4]  = mk(3'b010, 12'h0C0, 48'h0000_1234_0000, 1'b0, 3'b010, 1'b1, 4'h1, 16'hAAAA, 1'b0);
      vecs[5]  = mk(3'b000, 12'h000, 48'h0,              1'b0, 3'b000, 1'b1, 4'hC, 16'h1234, 1'b0);
      vecs[6]  = mk(3'b000, 12'h000, 48'h0,              1'b0, 3'b000, 1'b0, 4'h0, 16'h0000, 1'b0);
      vecs[7]  = mk(3'b001, 12'h00E, 48'h0000_0000_FFFF, 1'b0, 3'b001, 1'b0, 4'h0, 16'h0000, 1'b0);
      vecs[8]  = mk(3'b001, 12'h00F, 48'h0000_0000_5555, 1'b1, 3'b001, 1'b0, 4'h0, 16'h0000, 1'b1);
      vecs[9]  = mk(3'b000, 12'h000, 48'h0,              1'b0, 3'b000, 1'b0, 4'h0, 16'h0000, 1'b1);
      vecs[10] = mk(3'b000, 12'h000, 48'h0,              1'b1, 3'b000, 1'b0, 4'h0, 16'h0000, 1'b1);
      vecs[11] = mk(3'b000, 12'h000, 48'h0,              1'b0, 3'b000, 1'b0, 4'h0, 16'h0000, 1'b0);

      // reset values
      #1;
      chk("rst_we", 32'(write_en), 32'd0);
      chk("rst_wa", 32'(write_addr), 32'd0);
      chk("rst_wd", 32'(write_data), 32'd0);
      chk("rst_ack", 32'(sw_ack), 32'd0);
      chk("rst_drop", 32'(drop_err), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // table: round robin, single write, read-only drops, err_clr priority
      for (int i = 0; i < 12; i++) begin
         req_valid = vecs[i].valid; req_addr = vecs[i].addr;
         req_data = vecs[i].data; err_clr = vecs[i].clr;
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
         chk($sformatf("tbl%0d_we", i), 32'(write_en), 32'(vecs[i].e_we));
         chk($sformatf("tbl%0d_drop", i), 32'(drop_err), 32'(vecs[i].e_drop));
         if (vecs[i].e_we) begin
            chk($sformatf("tbl%0d_wa", i), 32'(write_addr), 32'(vecs[i].e_wa));
            chk($sformatf("tbl%0d_wd", i), 32'(write_data), 32'(vecs[i].e_wd));
         end
         @(posedge clock);
         @(negedge clock);
      end

      // bank switch handshake
      do_reset();
      req_valid = 3'b001; req_addr = 12'h005; req_data = 48'h0505;
      cyc("sw_pre0", 3'b001, 1'b0, 1'b0);
      #1;
      chk("sw_pre1_wa", 32'(write_addr), 32'h5);
      chk("sw_pre1_wd", 32'(write_data), 32'h0505);
      #1;
      cyc("sw_pre1", 3'b001, 1'b1, 1'b0);
      sw_req = 1'b1;
      cyc("sw_first", 3'b000, 1'b1, 1'b0);
      cyc("sw_drain", 3'b000, 1'b0, 1'b0);
      cyc("sw_ackc", 3'b000, 1'b0, 1'b1);
      cyc("sw_wait0", 3'b000, 1'b0, 1'b0);
      cyc("sw_wait1", 3'b000, 1'b0, 1'b0);
      sw_req = 1'b0;
      cyc("sw_wait_rel", 3'b000, 1'b0, 1'b0);
      cyc("sw_resume", 3'b001, 1'b0, 1'b0);
      // request withdrawn during drain still completes the handshake
      sw_req = 1'b1;
      cyc("swd_first", 3'b000, 1'b1, 1'b0);
      sw_req = 1'b0;
      cyc("swd_drain", 3'b000, 1'b0, 1'b0);
      cyc("swd_ackc", 3'b000, 1'b0, 1'b1);
      cyc("swd_wait", 3'b000, 1'b0, 1'b0);
      cyc("swd_idle", 3'b001, 1'b0, 1'b0);

      // hold blocks grants without moving the pointer
      do_reset();
      req_valid = 3'b001; req_addr = 12'h007;
      cyc("hold_pre", 3'b001, 1'b0, 1'b0);
      req_valid = 3'b101; req_addr = 12'h907; req_data = 48'h9999_0000_7777; hold = 1'b1;
      cyc("hold0", 3'b000, 1'b1, 1'b0);
      cyc("hold1", 3'b000, 1'b0, 1'b0);
      cyc("hold2", 3'b000, 1'b0, 1'b0);
      hold = 1'b0;
      cyc("hold_rel", 3'b100, 1'b0, 1'b0);
      req_valid = 3'b000;
      #1;
      chk("hold_after_wa", 32'(write_addr), 32'h9);
      chk("hold_after_wd", 32'(write_data), 32'h9999);
      cyc("hold_after", 3'b000, 1'b1, 1'b0);

      // asynchronous reset with a write in the output stage and drop_err set
      do_reset();
      req_valid = 3'b001; req_addr = 12'h00E;
      cyc("rst_a", 3'b001, 1'b0, 1'b0);
      req_valid = 3'b010; req_addr = 12'h030;
      cyc("rst_b", 3'b010, 1'b0, 1'b0);
      req_valid = 3'b000; sw_req = 1'b1;
      #1;
      chk("rst_mid_pre_we", 32'(write_en), 32'd1);
      chk("rst_mid_pre_drop", 32'(drop_err), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_mid_we", 32'(write_en), 32'd0);
      chk("rst_mid_drop", 32'(drop_err), 32'd0);
      chk("rst_mid_ack", 32'(sw_ack), 32'd0);
      @(negedge clock);
      reset = 1'b0; sw_req = 1'b0; req_valid = 3'b111;
      cyc("rst_mid_idle", 3'b001, 1'b0, 1'b0);
      // reset during the ack cycle
      req_valid = 3'b000; sw_req = 1'b1;
      cyc("rst_ack_c0", 3'b000, 1'b1, 1'b0);
      cyc("rst_ack_c1", 3'b000, 1'b0, 1'b0);
      #1;
      chk("rst_ack_pre", 32'(sw_ack), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_ack_clr", 32'(sw_ack), 32'd0);
      @(negedge clock);
      reset = 1'b0; sw_req = 1'b0; req_valid = 3'b100;
      cyc("rst_ack_idle", 3'b100, 1'b0, 1'b0);

      // randomized traffic against a reference model
      do_reset();
      m_ptr = 0; m_phase = 0; m_we = 1'b0; m_drop = 1'b0; m_wa = '0; m_wd = '0;
      rs = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rv = 3'($urandom);
         ra = 12'($urandom);
         rd = {16'($urandom), 16'($urandom), 16'($urandom)};
         rh = ($urandom_range(0, 5) == 0);
         rc = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) rs = ~rs;
         req_valid = rv; req_addr = ra; req_data = rd;
         hold = rh; sw_req = rs; err_clr = rc;
         #1;
         gi = (m_phase == 0 && !rh && !rs) ? pick(rv, m_ptr) : -1;
         exp_ready = (gi >= 0) ? 3'(1 << gi) : 3'b000;
         chk("rand_ready", 32'(req_ready), 32'(exp_ready));
         chk("rand_we", 32'(write_en), 32'(m_we));
         chk("rand_wa", 32'(write_addr), 32'(m_wa));
         chk("rand_wd", 32'(write_data), 32'(m_wd));
         chk("rand_ack", 32'(sw_ack), 32'(m_phase == 2));
         chk("rand_drop", 32'(drop_err), 32'(m_drop));
         @(posedge clock);
         case (m_phase)
            0: if (rs) m_phase = 1;
            1: if (!m_we) m_phase = 2;
            2: m_phase = 3;
            default: if (!rs) m_phase = 0;
         endcase
         if (rc) m_drop = 1'b0;
         if (gi >= 0) begin
            ga = 4'(ra >> (gi * AW));
            m_wa = ga;
            m_wd = 16'(rd >> (gi * DW));
            m_we = (ga < 4'hD);
            if (ga >= 4'hD) m_drop = 1'b1;
            m_ptr = (gi + 1) % N;
         end else begin
            m_we = 1'b0;
         end
         @(negedge clock);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
